lagd_fifo_push_sched: RTL and testbench



---
 rtl/lagd_fifo_push_sched.sv | 116 +++++++++++
 tb/tb_lagd_fifo_push_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lagd_fifo_push_sched.sv
// lagd_fifo_push_sched: round-robin push scheduler in front of one shared lagd_fifo_v3.
// Arbitrates NUM_REQ push requesters onto a single FIFO write port, sequences a
// one-cycle FIFO flush and stalls requesters while the FIFO is full or being flushed.
// Optional per-requester grant statistics are enabled with the macro
// LAGD_FIFO_PUSH_SCHED_STATS_EN (adds grant_cnt_o, 16-bit saturating counters).
module lagd_fifo_push_sched #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          flush_req_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_none_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic                          fifo_push_none_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_flush_o,
  output logic [IDX_W-1:0]              grant_idx_o,
`ifdef LAGD_FIFO_PUSH_SCHED_STATS_EN
  output logic [NUM_REQ*16-1:0]         grant_cnt_o,
`endif
  output logic                          busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_HOLD} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             grant;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Unpack the flat data bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grants only in RUN with room in the FIFO; a flush request or reset in the
  // same cycle suppresses the grant so no word is pushed into a FIFO being cleared.
  assign grant = !rst_i && (state_q == ST_RUN) && en_i && !flush_req_i
                 && !fifo_full_i && win_found;

  assign rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = grant && (win_idx == IDX_W'(gi));
  end

  assign fifo_push_o      = grant;
  assign fifo_push_none_o = grant && req_none_i[win_idx];
  assign fifo_data_o      = grant ? data_arr[win_idx] : '0;
  assign grant_idx_o      = grant ? win_idx : '0;
  // Outputs are held low during reset so a reset landing on FLUSH never pulses flush.
  assign fifo_flush_o     = !rst_i && (state_q == ST_FLUSH);
  assign busy_o           = !rst_i && ((state_q == ST_FLUSH) || (state_q == ST_HOLD));

  // Scheduler FSM and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
    end else begin
      if (grant) rr_ptr_q <= rr_ptr_d;
      case (state_q)
        ST_IDLE:  if (flush_req_i) state_q <= ST_FLUSH;
                  else if (en_i)   state_q <= ST_RUN;
        ST_RUN:   if (flush_req_i) state_q <= ST_FLUSH;
                  else if (!en_i)  state_q <= ST_IDLE;
        ST_FLUSH: state_q <= ST_HOLD;
        ST_HOLD:  if (!flush_req_i) state_q <= en_i ? ST_RUN : ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LAGD_FIFO_PUSH_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    // Saturating grant counter, cleared together with the FIFO contents.
    always_ff @(posedge clk_i) begin
      if (rst_i || (state_q == ST_FLUSH)) begin
        cnt_q[gi] <= '0;
      end else if (req_ready_o[gi] && (cnt_q[gi] != 16'hFFFF)) begin
        cnt_q[gi] <= cnt_q[gi] + 16'd1;
      end
    end
    assign grant_cnt_o[gi*16 +: 16] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_lagd_fifo_push_sched.sv
// Testbench for lagd_fifo_push_sched: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_lagd_fifo_push_sched;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i, en_i, flush_req_i, fifo_full_i;
  logic [N-1:0]  req_valid_i, req_none_i, req_ready_o;
  logic [N*DW-1:0] req_data_i;
  logic          fifo_push_o, fifo_push_none_o, fifo_flush_o, busy_o;
  logic [DW-1:0] fifo_data_o;
  logic [1:0]    grant_idx_o;
`ifdef LAGD_FIFO_PUSH_SCHED_STATS_EN
  logic [N*16-1:0] grant_cnt_o;
`endif

  always #5 clk = ~clk;

  lagd_fifo_push_sched #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .flush_req_i(flush_req_i),
    .req_valid_i(req_valid_i), .req_none_i(req_none_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .fifo_full_i(fifo_full_i), .fifo_push_o(fifo_push_o),
    .fifo_push_none_o(fifo_push_none_o), .fifo_data_o(fifo_data_o),
    .fifo_flush_o(fifo_flush_o), .grant_idx_o(grant_idx_o),
`ifdef LAGD_FIFO_PUSH_SCHED_STATS_EN
    .grant_cnt_o(grant_cnt_o),
`endif
    .busy_o(busy_o)
  );

  // Behavioural model: operating mode, next requester to favour, grant counts.
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_HOLD = 3;
  int m_mode = M_IDLE;
  int m_rr   = 0;
  int m_cnt [N];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic       obs_push, obs_flush, obs_none, obs_busy;
  logic [1:0] obs_idx;
  logic [DW-1:0] obs_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected winner: first valid requester counting up from m_rr modulo N, -1 if none.
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic check_outputs();
    int w;
    logic g;
    logic [N-1:0] e_ready;
    logic [DW-1:0] e_data;
    w = pick(req_valid_i);
    g = !rst_i && m_mode == M_RUN && en_i && !flush_req_i && !fifo_full_i && w >= 0;
    e_ready = g ? N'(1) << w : '0;
    e_data  = g ? req_data_i[w*DW +: DW] : '0;
    chk("ready", 128'(req_ready_o), 128'(e_ready));
    chk("push", 128'(fifo_push_o), 128'(g));
    chk("push_none", 128'(fifo_push_none_o), 128'(g && req_none_i[w < 0 ? 0 : w]));
    chk("data", 128'(fifo_data_o), 128'(e_data));
    chk("flush", 128'(fifo_flush_o), 128'(!rst_i && m_mode == M_FLUSH));
    chk("busy", 128'(busy_o), 128'(!rst_i && (m_mode == M_FLUSH || m_mode == M_HOLD)));
    if (g || rst_i) chk("grant_idx", 128'(grant_idx_o), 128'(g ? w : 0));
`ifdef LAGD_FIFO_PUSH_SCHED_STATS_EN
    for (int r = 0; r < N; r++) chk("grant_cnt", 128'(grant_cnt_o[r*16 +: 16]), 128'(m_cnt[r]));
`endif
    obs_push = fifo_push_o; obs_idx = grant_idx_o; obs_flush = fifo_flush_o;
    obs_none = fifo_push_none_o; obs_data = fifo_data_o; obs_busy = busy_o;
  endtask

  // Advance the model by one clock using the inputs that were applied for this cycle.
  task automatic model_step();
    int w;
    w = pick(req_valid_i);
    if (rst_i) begin
      m_mode = M_IDLE; m_rr = 0;
      for (int r = 0; r < N; r++) m_cnt[r] = 0;
      return;
    end
    if (m_mode == M_RUN && en_i && !flush_req_i && !fifo_full_i && w >= 0) begin
      m_rr = (w + 1) % N;
      if (m_cnt[w] < 65535) m_cnt[w]++;
    end
    if (m_mode == M_FLUSH)
      for (int r = 0; r < N; r++) m_cnt[r] = 0;
    case (m_mode)
      M_IDLE:  m_mode = flush_req_i ? M_FLUSH : (en_i ? M_RUN : M_IDLE);
      M_RUN:   m_mode = flush_req_i ? M_FLUSH : (en_i ? M_RUN : M_IDLE);
      M_FLUSH: m_mode = M_HOLD;
      default: m_mode = flush_req_i ? M_HOLD : (en_i ? M_RUN : M_IDLE);
    endcase
  endtask

  task automatic cycle(input logic rst, input logic en, input logic fl, input logic full,
                       input logic [N-1:0] v, input logic [N-1:0] nn);
    @(negedge clk);
    rst_i = rst; en_i = en; flush_req_i = fl; fifo_full_i = full;
    req_valid_i = v; req_none_i = nn;
    for (int r = 0; r < N; r++) req_data_i[r*DW +: DW] = $urandom;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  int flush_pulses;
  int got_push;

  initial begin
    for (int r = 0; r < N; r++) m_cnt[r] = 0;
    rst_i = 1'b1; en_i = 1'b0; flush_req_i = 1'b0; fifo_full_i = 1'b0;
    req_valid_i = '0; req_none_i = '0; req_data_i = '0;

    cycle(1, 0, 0, 0, 4'b1111, 4'b0000);
    cycle(1, 0, 0, 0, 4'b0000, 4'b0000);
    cycle(0, 0, 0, 0, 4'b0000, 4'b0000);
    chk("reset_push", 128'(obs_push), 128'(0));
    chk("reset_busy", 128'(obs_busy), 128'(0));

    // Fairness skip: idle cycle to enter RUN, then 1,3,1,3.
    cycle(0, 1, 0, 0, 4'b1010, 4'b0000);
    chk("idle_to_run_no_push", 128'(obs_push), 128'(0));
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, 0, 4'b1010, 4'b0000);
      chk("skip_idx", 128'(obs_idx), 128'((k % 2 == 0) ? 1 : 3));
    end

    // Round robin with everyone valid: pointer wrapped to 0 after grant 3.
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 0, 0, 4'b1111, 4'b0000);
      chk("rr_push", 128'(obs_push), 128'(1));
      chk("rr_idx", 128'(obs_idx), 128'(k % 4));
    end

    // Full stall then resume at the stalled pointer (0).
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 1, 4'b1111, 4'b0000);
      chk("full_no_push", 128'(obs_push), 128'(0));
    end
    cycle(0, 1, 0, 0, 4'b1111, 4'b0000);
    chk("full_resume_idx", 128'(obs_idx), 128'(0));

    // Slot-only push from requester 2.
    cycle(0, 1, 0, 0, 4'b0100, 4'b0100);
    chk("ph_push", 128'(obs_push), 128'(1));
    chk("ph_none", 128'(obs_none), 128'(1));
    chk("ph_data", 128'(obs_data), 128'(req_data_i[2*DW +: DW]));

    // Flush held for 3 cycles, then released.
    flush_pulses = 0; got_push = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 1, 0, 4'b1111, 4'b0000);
      flush_pulses += int'(obs_flush); got_push += int'(obs_push);
    end
    chk("flush_pulses", 128'(flush_pulses), 128'(1));
    chk("flush_no_grant", 128'(got_push), 128'(0));
    chk("flush_busy", 128'(obs_busy), 128'(1));
    cycle(0, 1, 0, 0, 4'b1111, 4'b0000);
    chk("hold_release_no_push", 128'(obs_push), 128'(0));
    cycle(0, 1, 0, 0, 4'b1111, 4'b0000);
    chk("run_resumed", 128'(obs_push), 128'(1));

    // Reset mid-RUN.
    cycle(1, 1, 0, 0, 4'b1111, 4'b0000);
    chk("rst_push", 128'(obs_push), 128'(0));
    cycle(0, 1, 0, 0, 4'b1111, 4'b0000);
    cycle(0, 1, 0, 0, 4'b1111, 4'b0000);
    chk("rst_rr_zero", 128'(obs_idx), 128'(0));

`ifdef LAGD_FIFO_PUSH_SCHED_STATS_EN
    // Saturation: single requester granted more than 65535 times.
    for (int k = 0; k < 65540; k++) cycle(0, 1, 0, 0, 4'b0001, 4'b0000);
    chk("cnt_sat", 128'(grant_cnt_o[15:0]), 128'(16'hFFFF));
`endif

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(199) == 0, $urandom_range(9) != 0, $urandom_range(14) == 0,
            $urandom_range(4) == 0, N'($urandom), N'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
